// File: rtl/univ_ff_bank.sv
// ============================================================================
// Module   : univ_ff_bank
// Brief    : Bank of WIDTH flip-flops run as D/T/SR/JK under a runtime mode,
//            with sticky SR-illegal error tracking and a saturating
//            transition counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sr_err,
    output logic [WIDTH-1:0] err_mask,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [1:0] c_MODE_D  = 2'b00;
    localparam logic [1:0] c_MODE_T  = 2'b01;
    localparam logic [1:0] c_MODE_SR = 2'b10;
    localparam logic [1:0] c_MODE_JK = 2'b11;

    localparam int c_PC_W = $clog2(WIDTH + 1);
    // Normally CNT_W+1; widened only when a full-bank popcount would not fit,
    // so saturation stays correct for narrow counters on wide banks.
    localparam int c_SUM_W = ((CNT_W > c_PC_W) ? CNT_W : c_PC_W) + 1;
    localparam logic [c_SUM_W-1:0] c_CNT_MAX = c_SUM_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] q_q, q_d;
    logic             sr_err_q, sr_err_d;
    logic [WIDTH-1:0] err_mask_q, err_mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]   w_illegal;
    logic [c_PC_W-1:0]  w_popcnt;
    logic [c_SUM_W-1:0] w_sum;

    always_comb begin
        q_d       = q_q;
        w_illegal = '0;
        if (en) begin
            case (mode)
                c_MODE_D: q_d = a;
                c_MODE_T: q_d = q_q ^ a;
                c_MODE_SR: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        case ({a[i], b[i]})
                            2'b10:   q_d[i] = 1'b1;
                            2'b01:   q_d[i] = 1'b0;
                            2'b11:   w_illegal[i] = 1'b1;
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                end
                c_MODE_JK: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        case ({a[i], b[i]})
                            2'b10:   q_d[i] = 1'b1;
                            2'b01:   q_d[i] = 1'b0;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + c_PC_W'(q_d[i] ^ q_q[i]);
        end
    end

    // A fresh illegal event on the clearing edge survives the clear.
    always_comb begin
        err_mask_d = (clr_err ? '0 : err_mask_q) | w_illegal;
        sr_err_d   = (clr_err ? 1'b0 : sr_err_q) | (|w_illegal);
    end

    always_comb begin
        w_sum = c_SUM_W'(clr_cnt ? '0 : cnt_q) + c_SUM_W'(w_popcnt);
        if (w_sum > c_CNT_MAX) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= RESET_VAL;
            sr_err_q   <= 1'b0;
            err_mask_q <= '0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            sr_err_q   <= sr_err_d;
            err_mask_q <= err_mask_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q        = q_q;
    assign qn       = ~q_q;
    assign sr_err   = sr_err_q;
    assign err_mask = err_mask_q;
    assign chg_cnt  = cnt_q;

endmodule

`default_nettype wire
